washer_ctrl: RTL and testbench
==============================

# washer_ctrl

Sequencing controller for the washing-machine datapath. Walks a wash program (fill, wash, drain, rinse loops, spin) and drives the actuator enables. Sits directly upstream of the phase-timer counter: `timer_start` feeds the counter's `start`, and the counter's `done` returns as `phase_done`. Handles lid-open pause and user cancel, and pulses `cycle_done` at program end.

## Interface
- `RINSE_COUNT`, default 1: number of (FILL, RINSE, DRAIN) rinse loops; legal range 1..7.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start_btn`  in  1  start request; sampled only in IDLE.
- `lid_open`  in  1  level; high pauses the program.
- `cancel`  in  1  level/pulse; aborts the program via an emergency drain.
- `phase_done`  in  1  from the phase timer; registered and sticky while `timer_start` is low.
- `timer_start`  out  1  enables the phase timer.
- `water_in`  out  1  fill valve.
- `agitate`  out  1  drum agitation.
- `drain_out`  out  1  drain pump.
- `spin`  out  1  high-speed spin.
- `busy`  out  1  high in any state except IDLE.
- `paused`  out  1  high in PAUSE.
- `cycle_done`  out  1  one-cycle pulse in FINISH.

## Operation
- States: IDLE, FILL, WASH, RINSE, DRAIN, SPIN, FINISH, PAUSE, CXL_DRAIN.
- Active phases are FILL, WASH, RINSE, DRAIN and SPIN.
- `rinse_idx` width is $clog2(RINSE_COUNT+1). It is cleared on leaving IDLE.
- Moore outputs, decoded from the state register:
  - `timer_start`: all active phases and CXL_DRAIN.
  - `water_in`: FILL.
  - `agitate`: WASH and RINSE.
  - `drain_out`: DRAIN, SPIN and CXL_DRAIN.
  - `spin`: SPIN.
- Reset: state IDLE, `rinse_idx`=0, saved phase = FILL, blank flag = 0. All outputs are 0.
- IDLE: if `start_btn` && !`lid_open`, go to FILL. `start_btn` is ignored in every other state.
- Phase order on `phase_done`:
  - FILL goes to WASH if `rinse_idx`==0, otherwise to RINSE.
  - WASH and RINSE go to DRAIN.
  - DRAIN: if `rinse_idx`<RINSE_COUNT, increment `rinse_idx` and go to FILL; otherwise go to SPIN.
  - SPIN goes to FINISH. FINISH goes to IDLE unconditionally.
- Priority in an active phase: `cancel` > `lid_open` > `phase_done`.
  - `cancel` goes to CXL_DRAIN.
  - `lid_open` goes to PAUSE and saves the current phase.
- PAUSE:
  - All actuators and `timer_start` are 0, so the timer holds its count.
  - `cancel` goes to CXL_DRAIN.
  - `lid_open`==0 returns to the saved phase, without blanking.
- CXL_DRAIN: `lid_open` and `cancel` are ignored. `phase_done` goes to IDLE. `cycle_done` is not pulsed.
- Entry blanking:
  - On entry to any active phase or CXL_DRAIN from a different non-PAUSE state, `phase_done` is ignored for the first cycle.
  - Purpose: discard the timer's sticky `done` left from the previous phase or run.
  - Resume from PAUSE is not blanked, so a completion latched at the pause edge still advances the program.

## Timing
- All decisions are taken on the clock edge that samples the inputs. The new state takes effect after that edge, and outputs follow in the same cycle.
- With the timer at COUNT_MAX=N, timer_start high continuously, and the counter's count starting at 0:
  - The first phase of a run lasts N+1 cycles.
  - Each subsequent phase lasts N cycles, because the timer restarts on the transition edge.
- Sampling `phase_done` and `lid_open` on the same edge goes to PAUSE. `done` stays held, and the phase advances on the first edge after resume.
- CXL_DRAIN length is set by the residual timer count: from 1 to N cycles after the blank cycle.
- Asynchronous reset mid-program returns to IDLE immediately, with all outputs 0.

## Test plan
Timer instance COUNT_MAX=5, RINSE_COUNT=1. Edge 0 samples `start_btn`.
- Full run:
  - Start at edge 0 -> FILL@0, WASH@6, DRAIN@11, FILL@16, RINSE@21, DRAIN@26, SPIN@31, FINISH@36.
  - `cycle_done`=1 for exactly one cycle, then IDLE@37 with `busy`=0.
- Back-to-back run: second start right after IDLE (`phase_done` still sticky 1) -> FILL again lasts 6 cycles; no early advance.
- Pause: `lid_open` sampled at edge 8 (WASH, count 3) and released at edge 12 -> PAUSE with all outputs 0, count held at 3. Then WASH@12 and DRAIN@15.
- Cancel: `cancel` at edge 8 -> CXL_DRAIN@8 with `drain_out`=1, then IDLE@11, with `cycle_done` never asserted.
- Start gating: `start_btn` with `lid_open`=1 -> remains IDLE. `start_btn` pulses mid-run -> no effect.
- Reset: `rstn` low at edge 23 (RINSE) -> all outputs 0 and `busy`=0 asynchronously. After release, a normal start reproduces the full-run timings.

Source files
------------

// File: rtl/washer_ctrl_if.sv
// Control bundle between the washer sequencer and its environment (buttons, lid
// sensor, phase timer and actuator drivers).
interface washer_ctrl_if;
   logic start_btn;
   logic lid_open;
   logic cancel;
   logic phase_done;
   logic timer_start;
   logic water_in;
   logic agitate;
   logic drain_out;
   logic spin;
   logic busy;
   logic paused;
   logic cycle_done;

   modport master (
      output start_btn, lid_open, cancel, phase_done,
      input  timer_start, water_in, agitate, drain_out, spin, busy, paused, cycle_done
   );

   modport slave (
      input  start_btn, lid_open, cancel, phase_done,
      output timer_start, water_in, agitate, drain_out, spin, busy, paused, cycle_done
   );
endinterface

// File: rtl/washer_ctrl.sv
// Wash-program sequencer: fill/wash/drain, rinse loops, spin; lid pause and
// cancel with emergency drain. Actuator enables are registered Moore outputs.
module washer_ctrl #(
   parameter int unsigned RINSE_COUNT = 1
) (
   input logic          clk,
   input logic          rstn,
   washer_ctrl_if.slave bus
);

   localparam int unsigned RW = $clog2(RINSE_COUNT + 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FILL,
      ST_WASH,
      ST_RINSE,
      ST_DRAIN,
      ST_SPIN,
      ST_FINISH,
      ST_PAUSE,
      ST_CXL_DRAIN
   } state_e;

   typedef struct packed {
      logic timer_start;
      logic water_in;
      logic agitate;
      logic drain_out;
      logic spin;
      logic busy;
      logic paused;
      logic cycle_done;
   } out_t;

   state_e        state_q, state_d;
   state_e        saved_q, saved_d;
   logic [RW-1:0] rinse_q, rinse_d;
   logic          blank_q, blank_d;
   logic          done_ok;
   out_t          out_q;

   // Output decode for a given state; applied to the next state so the
   // registered outputs line up with the state register.
   function automatic out_t decode(input state_e s);
      out_t o;
      o             = '0;
      o.busy        = (s != ST_IDLE);
      o.paused      = (s == ST_PAUSE);
      o.cycle_done  = (s == ST_FINISH);
      o.water_in    = (s == ST_FILL);
      o.agitate     = (s == ST_WASH) || (s == ST_RINSE);
      o.spin        = (s == ST_SPIN);
      o.drain_out   = (s == ST_DRAIN) || (s == ST_SPIN) || (s == ST_CXL_DRAIN);
      o.timer_start = (s == ST_FILL) || (s == ST_WASH) || (s == ST_RINSE) ||
                      (s == ST_DRAIN) || (s == ST_SPIN) || (s == ST_CXL_DRAIN);
      return o;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         saved_q <= ST_FILL;
         rinse_q <= '0;
         blank_q <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         rinse_q <= rinse_d;
         blank_q <= blank_d;
         out_q   <= decode(state_d);
      end
   end

   // blank_q masks the timer's stale done during the first cycle of a fresh phase
   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      rinse_d = rinse_q;
      blank_d = 1'b0;
      done_ok = bus.phase_done && !blank_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_btn && !bus.lid_open) begin
               state_d = ST_FILL;
               rinse_d = '0;
               blank_d = 1'b1;
            end
         end

         ST_FILL, ST_WASH, ST_RINSE, ST_DRAIN, ST_SPIN: begin
            if (bus.cancel) begin
               state_d = ST_CXL_DRAIN;
               blank_d = 1'b1;
            end else if (bus.lid_open) begin
               state_d = ST_PAUSE;
               saved_d = state_q;
            end else if (done_ok) begin
               blank_d = 1'b1;
               case (state_q)
                  ST_FILL:  state_d = (rinse_q == '0) ? ST_WASH : ST_RINSE;
                  ST_WASH,
                  ST_RINSE: state_d = ST_DRAIN;
                  ST_DRAIN: begin
                     if (rinse_q < RW'(RINSE_COUNT)) begin
                        rinse_d = rinse_q + RW'(1);
                        state_d = ST_FILL;
                     end else begin
                        state_d = ST_SPIN;
                     end
                  end
                  default:  state_d = ST_FINISH;
               endcase
            end
         end

         ST_FINISH: state_d = ST_IDLE;

         // Resume is deliberately unblanked so a done latched at the pause edge still counts
         ST_PAUSE: begin
            if (bus.cancel) begin
               state_d = ST_CXL_DRAIN;
               blank_d = 1'b1;
            end else if (!bus.lid_open) begin
               state_d = saved_q;
            end
         end

         ST_CXL_DRAIN: begin
            if (done_ok) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.timer_start = out_q.timer_start;
   assign bus.water_in    = out_q.water_in;
   assign bus.agitate     = out_q.agitate;
   assign bus.drain_out   = out_q.drain_out;
   assign bus.spin        = out_q.spin;
   assign bus.busy        = out_q.busy;
   assign bus.paused      = out_q.paused;
   assign bus.cycle_done  = out_q.cycle_done;

endmodule

// File: tb/tb_washer_ctrl.sv
// Bench for washer_ctrl: directed program timings against a modelled phase timer
// (COUNT_MAX=5), then random inputs checked against a program-list reference model.
module tb_washer_ctrl;

   localparam int N     = 5;
   localparam int RINSE = 1;

   // Output vector layout: {timer_start, water_in, agitate, drain_out, spin, busy, paused, cycle_done}
   localparam logic [7:0] V_IDLE  = 8'b0000_0000;
   localparam logic [7:0] V_FILL  = 8'b1100_0100;
   localparam logic [7:0] V_AGIT  = 8'b1010_0100;
   localparam logic [7:0] V_DRAIN = 8'b1001_0100;
   localparam logic [7:0] V_SPIN  = 8'b1001_1100;
   localparam logic [7:0] V_FIN   = 8'b0000_0101;
   localparam logic [7:0] V_PAUSE = 8'b0000_0110;
   localparam logic [7:0] V_CXL   = 8'b1001_0100;

   localparam int P_FILL = 0, P_WASH = 1, P_RINSE = 2, P_DRAIN = 3, P_SPIN = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_CXL = 3, M_FIN = 4;

   logic clk;
   logic rstn;
   washer_ctrl_if bus();

   washer_ctrl #(.RINSE_COUNT(RINSE)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int e    = -1;

   // Reference model: position in a flat list of program phases
   int prog[$];
   int mode;
   int k;
   bit blank;

   // Phase-timer model
   int  t_cnt;
   bit  t_done;
   bit  use_timer;

   function automatic logic [7:0] dut_vec();
      return {bus.timer_start, bus.water_in, bus.agitate, bus.drain_out,
              bus.spin, bus.busy, bus.paused, bus.cycle_done};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
      end
   endtask

   function automatic logic [7:0] model_out();
      case (mode)
         M_RUN: begin
            case (prog[k])
               P_FILL:  return V_FILL;
               P_WASH:  return V_AGIT;
               P_RINSE: return V_AGIT;
               P_DRAIN: return V_DRAIN;
               default: return V_SPIN;
            endcase
         end
         M_PAUSE: return V_PAUSE;
         M_CXL:   return V_CXL;
         M_FIN:   return V_FIN;
         default: return V_IDLE;
      endcase
   endfunction

   task automatic model_reset();
      mode  = M_IDLE;
      k     = 0;
      blank = 1'b0;
   endtask

   task automatic model_update(input bit s, input bit l, input bit c, input bit d);
      bit dv;
      bit nb;
      dv = d && !blank;
      nb = 1'b0;
      case (mode)
         M_IDLE:  if (s && !l) begin mode = M_RUN; k = 0; nb = 1'b1; end
         M_RUN: begin
            if (c) begin mode = M_CXL; nb = 1'b1; end
            else if (l) mode = M_PAUSE;
            else if (dv) begin
               k++;
               if (k == prog.size()) mode = M_FIN;
               else nb = 1'b1;
            end
         end
         M_PAUSE: begin
            if (c) begin mode = M_CXL; nb = 1'b1; end
            else if (!l) mode = M_RUN;
         end
         M_CXL:   if (dv) mode = M_IDLE;
         default: mode = M_IDLE;
      endcase
      blank = nb;
   endtask

   // Counter emulation: wraps after N enabled cycles, done held while disabled
   task automatic timer_update(input bit ts);
      if (ts) begin
         if (t_cnt == N - 1) begin t_cnt = 0; t_done = 1'b1; end
         else begin t_cnt++; t_done = 1'b0; end
      end
      bus.phase_done = t_done;
   endtask

   task automatic arm_timer(input bit done_v);
      t_cnt          = 0;
      t_done         = done_v;
      bus.phase_done = done_v;
   endtask

   task automatic step(input string tag);
      bit s, l, c, d, ts;
      s  = bus.start_btn;
      l  = bus.lid_open;
      c  = bus.cancel;
      d  = bus.phase_done;
      ts = bus.timer_start;
      @(posedge clk);
      #1;
      e++;
      model_update(s, l, c, d);
      if (use_timer) timer_update(ts);
      chk(tag, dut_vec(), model_out());
   endtask

   function automatic logic [7:0] spec_full(input int r);
      if (r < 6)   return V_FILL;
      if (r < 11)  return V_AGIT;
      if (r < 16)  return V_DRAIN;
      if (r < 21)  return V_FILL;
      if (r < 26)  return V_AGIT;
      if (r < 31)  return V_DRAIN;
      if (r < 36)  return V_SPIN;
      if (r == 36) return V_FIN;
      return V_IDLE;
   endfunction

   task automatic full_run();
      bus.start_btn = 1'b1;
      step("model_full");
      bus.start_btn = 1'b0;
      chk("full_r0", dut_vec(), spec_full(0));
      for (int r = 1; r <= 37; r++) begin
         bus.start_btn = (r == 20);
         step("model_full");
         chk($sformatf("full_r%0d", r), dut_vec(), spec_full(r));
      end
      bus.start_btn = 1'b0;
   endtask

   task automatic start_and_run(input int upto);
      bus.start_btn = 1'b1;
      step("model_start");
      bus.start_btn = 1'b0;
      for (int r = 1; r <= upto; r++) step("model_run");
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy && n < 60) begin
         step("model_drain");
         n++;
      end
      chk(tag, {7'b0, bus.busy}, 8'h00);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit cd_seen;
      prog = {P_FILL, P_WASH, P_DRAIN};
      for (int r = 0; r < RINSE; r++) begin
         prog.push_back(P_FILL);
         prog.push_back(P_RINSE);
         prog.push_back(P_DRAIN);
      end
      prog.push_back(P_SPIN);

      rstn          = 1'b0;
      bus.start_btn = 1'b0;
      bus.lid_open  = 1'b0;
      bus.cancel    = 1'b0;
      use_timer     = 1'b1;
      arm_timer(1'b0);
      model_reset();
      #12;
      chk("reset_outputs", dut_vec(), V_IDLE);
      rstn = 1'b1;
      step("model_idle");

      // Start is refused while the lid is open
      bus.lid_open  = 1'b1;
      bus.start_btn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("model_gate");
         chk("start_lid_open", dut_vec(), V_IDLE);
      end
      bus.lid_open  = 1'b0;
      bus.start_btn = 1'b0;
      step("model_idle");

      full_run();

      // Back-to-back start with a stale done still held by the timer
      arm_timer(1'b1);
      start_and_run(5);
      chk("b2b_fill_r5", dut_vec(), V_FILL);
      step("model_b2b");
      chk("b2b_wash_r6", dut_vec(), V_AGIT);
      bus.cancel = 1'b1;
      step("model_b2b");
      bus.cancel = 1'b0;
      wait_idle("b2b_idle");

      // Lid pause in WASH holds the timer and resumes without blanking
      arm_timer(1'b0);
      start_and_run(7);
      bus.lid_open = 1'b1;
      step("model_pause");
      chk("pause_r8", dut_vec(), V_PAUSE);
      step("model_pause");
      step("model_pause");
      step("model_pause");
      chk("pause_r11", dut_vec(), V_PAUSE);
      bus.lid_open = 1'b0;
      step("model_pause");
      chk("resume_wash_r12", dut_vec(), V_AGIT);
      step("model_pause");
      step("model_pause");
      chk("resume_wash_r14", dut_vec(), V_AGIT);
      step("model_pause");
      chk("resume_drain_r15", dut_vec(), V_DRAIN);
      bus.cancel = 1'b1;
      step("model_pause");
      bus.cancel = 1'b0;
      wait_idle("pause_idle");

      // Cancel in WASH: emergency drain, no completion pulse
      arm_timer(1'b0);
      start_and_run(7);
      bus.cancel = 1'b1;
      step("model_cxl");
      bus.cancel = 1'b0;
      chk("cxl_r8", dut_vec(), V_CXL);
      cd_seen = bus.cycle_done;
      step("model_cxl");
      cd_seen |= bus.cycle_done;
      step("model_cxl");
      cd_seen |= bus.cycle_done;
      chk("cxl_r10", dut_vec(), V_CXL);
      step("model_cxl");
      cd_seen |= bus.cycle_done;
      chk("cxl_idle_r11", dut_vec(), V_IDLE);
      chk("cxl_no_cycle_done", {7'b0, cd_seen}, 8'h00);

      // Asynchronous reset in RINSE, then a clean full run
      arm_timer(1'b0);
      start_and_run(23);
      chk("rst_pre_rinse", dut_vec(), V_AGIT);
      #2;
      rstn = 1'b0;
      #1;
      chk("rst_async", dut_vec(), V_IDLE);
      model_reset();
      #3;
      rstn = 1'b1;
      arm_timer(1'b0);
      full_run();

      // Random inputs, phase_done driven directly
      use_timer = 1'b0;
      for (int i = 0; i < 400; i++) begin
         bus.start_btn = ($urandom_range(3) == 0);
         if ($urandom_range(9) == 0) bus.lid_open = ~bus.lid_open;
         bus.cancel     = ($urandom_range(29) == 0);
         bus.phase_done = ($urandom_range(2) == 0);
         step("model_rand");
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
